freq_sweep: RTL and testbench

FREQ_SWEEP -- requirements
Module: freq_sweep

---
 rtl/mawg_pkg.sv | 17 +
 rtl/freq_sweep_if.sv | 35 +++
 rtl/freq_sweep_dwell_timer.sv | 38 +++
 rtl/freq_sweep.sv | 146 ++++++++++++++
 tb/tb_freq_sweep.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mawg_pkg.sv
// Shared definitions for the waveform-generator blocks.
// Holds the default control-word widths and the sweep state encoding
// so the sweep controller and anything that observes it agree.
package mawg_pkg;

  localparam int FCW_W_DEFAULT   = 32;
  localparam int DWELL_W_DEFAULT = 16;

  // IDLE: waiting for start; RUN: stepping toward stop_word;
  // LAST: holding stop_word for its final dwell.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/freq_sweep_if.sv
// Control/status bundle between a sweep requester and freq_sweep.
// Requester side (master) drives the sweep request and configuration;
// the sweep engine (slave) returns the control word and status.
//   start, abort                    : request strobes
//   start_word, stop_word, step     : sweep range and step magnitude
//   dwell                           : clocks each word is held
//   repeat_mode                     : 0 = one-shot, 1 = loop passes
//   ctrl, busy, done                : control word and sweep status
interface freq_sweep_if #(
  parameter int FCW_W   = 32,
  parameter int DWELL_W = 16
);

  logic               start;
  logic               abort;
  logic [FCW_W-1:0]   start_word;
  logic [FCW_W-1:0]   stop_word;
  logic [FCW_W-1:0]   step;
  logic [DWELL_W-1:0] dwell;
  logic               repeat_mode;
  logic [FCW_W-1:0]   ctrl;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, start_word, stop_word, step, dwell, repeat_mode,
    input  ctrl, busy, done
  );

  modport slave (
    input  start, abort, start_word, stop_word, step, dwell, repeat_mode,
    output ctrl, busy, done
  );

endinterface

// File: rtl/freq_sweep_dwell_timer.sv
// Dwell timer for the frequency sweep.
// Loads a hold length D (>= 1) and counts down once per clock; o_expire
// is high during the last clock of the hold so the controller can load
// the next word (and reload the timer) on that same edge.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load i_value into the counter
//   i_clear   : force the counter to zero (no further expiry)
//   i_value   : hold length in clocks
//   o_expire  : one-cycle flag, last clock of the current hold
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_value,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_count;

  // A count of zero means idle, so expiry can only follow a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - DWELL_W'(1);
    end
  end

  assign o_expire = (r_count == DWELL_W'(1));

endmodule

// File: rtl/freq_sweep.sv
// Frequency sweep controller.
// Steps a frequency control word from start_word toward stop_word by
// max(step,1), holding each word max(dwell,1) clocks. The final word is
// clamped to stop_word, so the output never overshoots or wraps. Passes
// repeat when repeat_mode was set at start. abort returns to IDLE with
// ctrl frozen.
//   clk, rst : clock, synchronous active-high reset
//   bus      : freq_sweep_if slave (request/config in, ctrl/busy/done out)
module freq_sweep
  import mawg_pkg::*;
#(
  parameter int FCW_W   = FCW_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  freq_sweep_if.slave bus
);

  sweep_state_e       r_state, w_stateNext;
  logic [FCW_W-1:0]   r_ctrl, w_ctrlNext;
  logic               r_busy, w_busyNext;
  logic               r_done, w_doneNext;
  logic [FCW_W-1:0]   r_startWord, r_stopWord, r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_repeat;

  logic               w_latch, w_timerLoad, w_timerClear, w_expire;
  logic [DWELL_W-1:0] w_dwellIn, w_dwellEff, w_timerValue;
  logic [FCW_W-1:0]   w_stepEff, w_nextWord;
  logic [FCW_W:0]     w_nextWide;
  logic               w_up, w_hitStop;

  // Zero dwell and zero step are promoted to one so the sweep always advances.
  assign w_dwellIn    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign w_dwellEff   = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
  assign w_timerValue = w_latch ? w_dwellIn : w_dwellEff;
  assign w_stepEff    = (r_step == '0) ? FCW_W'(1) : r_step;

  // The extra top bit catches carry-out when sweeping up and borrow when
  // sweeping down, so a step that runs past the numeric range still clamps.
  assign w_up       = (r_stopWord >= r_startWord);
  assign w_nextWide = w_up ? ({1'b0, r_ctrl} + {1'b0, w_stepEff})
                           : ({1'b0, r_ctrl} - {1'b0, w_stepEff});
  assign w_hitStop  = w_up ? (w_nextWide >= {1'b0, r_stopWord})
                           : (w_nextWide[FCW_W] || (w_nextWide[FCW_W-1:0] <= r_stopWord));
  assign w_nextWord = w_hitStop ? r_stopWord : w_nextWide[FCW_W-1:0];

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timerLoad),
    .i_clear  (w_timerClear),
    .i_value  (w_timerValue),
    .o_expire (w_expire)
  );

  // State, output and configuration registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ctrl      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_startWord <= '0;
      r_stopWord  <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_repeat    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ctrl  <= w_ctrlNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
      if (w_latch) begin
        r_startWord <= bus.start_word;
        r_stopWord  <= bus.stop_word;
        r_step      <= bus.step;
        r_dwell     <= bus.dwell;
        r_repeat    <= bus.repeat_mode;
      end
    end
  end

  // Next-state logic. abort is checked first in every state so it beats
  // both a simultaneous start and a final-dwell done.
  always_comb begin
    w_stateNext  = r_state;
    w_ctrlNext   = r_ctrl;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    w_latch      = 1'b0;
    w_timerLoad  = 1'b0;
    w_timerClear = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.abort && bus.start) begin
          w_latch     = 1'b1;
          w_timerLoad = 1'b1;
          w_ctrlNext  = bus.start_word;
          w_busyNext  = 1'b1;
          w_stateNext = (bus.start_word == bus.stop_word) ? LAST : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_stateNext  = IDLE;
          w_busyNext   = 1'b0;
          w_timerClear = 1'b1;
        end else if (w_expire) begin
          w_timerLoad = 1'b1;
          w_ctrlNext  = w_nextWord;
          if (w_hitStop) w_stateNext = LAST;
        end
      end
      LAST: begin
        if (bus.abort) begin
          w_stateNext  = IDLE;
          w_busyNext   = 1'b0;
          w_timerClear = 1'b1;
        end else if (w_expire) begin
          w_doneNext = 1'b1;
          if (r_repeat) begin
            w_timerLoad = 1'b1;
            w_ctrlNext  = r_startWord;
            w_stateNext = (r_startWord == r_stopWord) ? LAST : RUN;
          end else begin
            w_stateNext  = IDLE;
            w_busyNext   = 1'b0;
            w_timerClear = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext  = IDLE;
        w_busyNext   = 1'b0;
        w_timerClear = 1'b1;
      end
    endcase
  end

  assign bus.ctrl = r_ctrl;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_freq_sweep.sv
// Directed testbench for freq_sweep: up/down sweeps, clamping at the
// numeric range edge, repeat with zero step/dwell, abort and reset.
module tb_freq_sweep;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  freq_sweep_if #(.FCW_W(32), .DWELL_W(16)) sweepIf ();

  freq_sweep #(.FCW_W(32), .DWELL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sweepIf.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance one edge; inputs and samples settle 1 ns after the edge
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] c,
                            input logic b, input logic d);
    checkOutput($sformatf("%s ctrl", tag), 64'(sweepIf.ctrl), 64'(c));
    checkOutput($sformatf("%s busy", tag), 64'(sweepIf.busy), 64'(b));
    checkOutput($sformatf("%s done", tag), 64'(sweepIf.done), 64'(d));
  endtask

  // Present a configuration and pulse start for one edge, then scramble
  // the configuration inputs so a running sweep must use its latched copy
  task automatic applyStimulus(input logic [31:0] sw, input logic [31:0] ew,
                               input logic [31:0] st, input logic [15:0] dw,
                               input logic rp);
    sweepIf.start_word  = sw;
    sweepIf.stop_word   = ew;
    sweepIf.step        = st;
    sweepIf.dwell       = dw;
    sweepIf.repeat_mode = rp;
    sweepIf.start       = 1'b1;
    stepClk();
    sweepIf.start       = 1'b0;
    sweepIf.start_word  = 32'h0000_0777;
    sweepIf.stop_word   = 32'h0000_0001;
    sweepIf.step        = 32'h0000_0003;
    sweepIf.dwell       = 16'd9;
    sweepIf.repeat_mode = ~rp;
  endtask

  logic [31:0] upSeq   [8] = '{100, 100, 110, 110, 120, 120, 130, 130};
  logic [31:0] downSeq [4] = '{50, 38, 26, 20};
  logic [31:0] ovfSeq  [6] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] repSeq  [7] = '{5, 6, 7, 5, 6, 7, 5};
  logic        repDone [7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    checkCount = 0;
    passCount  = 0;
    sweepIf.start       = 1'b0;
    sweepIf.abort       = 1'b0;
    sweepIf.start_word  = '0;
    sweepIf.stop_word   = '0;
    sweepIf.step        = '0;
    sweepIf.dwell       = '0;
    sweepIf.repeat_mode = 1'b0;

    // Reset with start requested: reset must win
    rst = 1'b1;
    sweepIf.start_word = 32'd44;
    sweepIf.stop_word  = 32'd60;
    sweepIf.start      = 1'b1;
    stepClk();
    stepClk();
    checkState("reset", 32'd0, 1'b0, 1'b0);
    sweepIf.start = 1'b0;
    rst = 1'b0;
    stepClk();
    checkState("idle", 32'd0, 1'b0, 1'b0);

    // Up sweep; a start while busy mid-sweep must be ignored
    $display("[TB] up sweep");
    applyStimulus(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkState($sformatf("up[%0d]", i), upSeq[i], 1'b1, 1'b0);
      sweepIf.start = (i == 2);
      stepClk();
    end
    sweepIf.start = 1'b0;
    checkState("up end", 32'd130, 1'b0, 1'b1);
    stepClk();
    checkState("up hold", 32'd130, 1'b0, 1'b0);

    // Down sweep with clamp onto stop_word
    $display("[TB] down sweep");
    applyStimulus(32'd50, 32'd20, 32'd12, 16'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkState($sformatf("down[%0d]", i), downSeq[i], 1'b1, 1'b0);
      stepClk();
    end
    checkState("down end", 32'd20, 1'b0, 1'b1);
    stepClk();
    checkState("down hold", 32'd20, 1'b0, 1'b0);

    // Near the top of the range: must clamp, not wrap
    $display("[TB] overflow clamp");
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("ovf[%0d] ctrl", i), 64'(sweepIf.ctrl), 64'(ovfSeq[i]));
      stepClk();
    end
    checkState("ovf end", 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Repeat with step=0 and dwell=0 (both treated as 1)
    $display("[TB] repeat");
    applyStimulus(32'd5, 32'd7, 32'd0, 16'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      checkState($sformatf("rep[%0d]", i), repSeq[i], 1'b1, repDone[i]);
      stepClk();
    end
    // ctrl is now 6; abort freezes it
    sweepIf.abort = 1'b1;
    stepClk();
    sweepIf.abort = 1'b0;
    checkState("rep abort", 32'd6, 1'b0, 1'b0);

    // Abort together with start while idle: abort wins
    sweepIf.start_word = 32'd900;
    sweepIf.stop_word  = 32'd950;
    sweepIf.abort = 1'b1;
    sweepIf.start = 1'b1;
    stepClk();
    sweepIf.abort = 1'b0;
    sweepIf.start = 1'b0;
    checkState("idle abort+start", 32'd6, 1'b0, 1'b0);

    // Abort at ctrl=120 with a simultaneous start
    $display("[TB] abort mid-sweep");
    applyStimulus(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    for (int i = 0; i < 4; i++) stepClk();
    checkState("pre-abort", 32'd120, 1'b1, 1'b0);
    sweepIf.start_word = 32'd300;
    sweepIf.stop_word  = 32'd400;
    sweepIf.abort = 1'b1;
    sweepIf.start = 1'b1;
    stepClk();
    sweepIf.abort = 1'b0;
    sweepIf.start = 1'b0;
    checkState("abort", 32'd120, 1'b0, 1'b0);
    stepClk();
    checkState("abort hold", 32'd120, 1'b0, 1'b0);

    // Final-dwell abort beats done
    applyStimulus(32'd50, 32'd20, 32'd12, 16'd1, 1'b0);
    stepClk();
    stepClk();
    stepClk();
    checkOutput("last ctrl", 64'(sweepIf.ctrl), 64'd20);
    sweepIf.abort = 1'b1;
    stepClk();
    sweepIf.abort = 1'b0;
    checkState("last abort", 32'd20, 1'b0, 1'b0);

    // Reset mid-sweep, then a normal sweep
    $display("[TB] reset mid-sweep");
    applyStimulus(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    stepClk();
    stepClk();
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkState("mid reset", 32'd0, 1'b0, 1'b0);
    applyStimulus(32'd50, 32'd20, 32'd12, 16'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkState($sformatf("post[%0d]", i), downSeq[i], 1'b1, 1'b0);
      stepClk();
    end
    checkState("post end", 32'd20, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
